// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor slice:
// PC-select encodings, counter state names and default widths.
package bp_pkg;

  localparam int IDX_W_DEF  = 6;
  localparam int CTR_W_DEF  = 2;
  localparam int STAT_W_DEF = 16;

  typedef enum logic [1:0] {
    PC_ADD4     = 2'd0,
    PC_JALR     = 2'd1,
    ALU_ANS     = 2'd2,
    BRANCH_ADDR = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_state_e;

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating next-state function; UP_ONLY=1 turns it
// into an increment-only counter that sticks at all-ones.
module bp_sat_counter #(
  parameter int W       = 2,
  parameter bit UP_ONLY = 1'b0
) (
  input  logic [W-1:0] cur,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] nxt
);

  logic go_up;

  assign go_up = up | UP_ONLY;

  // Step toward the requested rail, holding at either end.
  always_comb begin
    nxt = cur;
    if (en) begin
      if (go_up) begin
        if (cur != {W{1'b1}}) nxt = cur + W'(1);
      end else begin
        if (cur != {W{1'b0}}) nxt = cur - W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// BHT branch predictor: combinational IF lookup, EX resolve/train.
// Optional gshare indexing when BHT_GSHARE_EN is defined.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int CTR_W    = CTR_W_DEF,
  parameter int INIT_CTR = 1,
  parameter int STAT_W   = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   pc_if,
  output logic              predict_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [IDX_W-1:0]  ex_idx,
  input  logic [1:0]        pc_sel_ex,
  input  logic              branch_predict_ex,
  output logic              branch_outcome,
  output logic              predict_outcome,
  output logic              pc_sel_default,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0]  bht [DEPTH];
  logic [IDX_W-1:0]  ghr;
  logic [IDX_W-1:0]  base_idx;
  logic              taken;
  logic              train;
  logic              mispred;
  logic [CTR_W-1:0]  ctr_nxt;
  logic [STAT_W-1:0] br_nxt;
  logic [STAT_W-1:0] mis_nxt;
  logic              pc_unused;

  assign base_idx = pc_if[IDX_W+1:2];

`ifdef BHT_GSHARE_EN
  assign pred_idx  = base_idx ^ ghr;
  assign pc_unused = ^{pc_if[PC_W-1:IDX_W+2], pc_if[1:0]};
`else
  assign pred_idx  = base_idx;
  assign pc_unused = ^{pc_if[PC_W-1:IDX_W+2], pc_if[1:0], ghr};
`endif

  assign predict_taken = bht[pred_idx][CTR_W-1];

  assign taken = (pc_sel_ex == PC_JALR) ||
                 (pc_sel_ex == ALU_ANS);
  assign train   = ex_valid & ex_is_branch;
  assign mispred = taken != branch_predict_ex;

  assign branch_outcome  = ex_valid & taken;
  assign predict_outcome = ~ex_valid | ~mispred;
  assign pc_sel_default  = ex_valid &
                           (pc_sel_ex == PC_ADD4) &
                           branch_predict_ex;

  bp_sat_counter #(.W(CTR_W), .UP_ONLY(1'b0)) u_ctr (
    .cur (bht[ex_idx]),
    .en  (train),
    .up  (taken),
    .nxt (ctr_nxt)
  );

  bp_sat_counter #(.W(STAT_W), .UP_ONLY(1'b1)) u_br (
    .cur (branch_cnt),
    .en  (train),
    .up  (1'b1),
    .nxt (br_nxt)
  );

  bp_sat_counter #(.W(STAT_W), .UP_ONLY(1'b1)) u_mis (
    .cur (mispredict_cnt),
    .en  (train & mispred),
    .up  (1'b1),
    .nxt (mis_nxt)
  );

  // Train the single entry named by the EX instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= CTR_W'(INIT_CTR);
    end else if (train) begin
      bht[ex_idx] <= ctr_nxt;
    end
  end

  // Global history and performance statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr            <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (train) begin
      ghr            <= {ghr[IDX_W-2:0], taken};
      branch_cnt     <= br_nxt;
      mispredict_cnt <= mis_nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht.
// Covers reset, training, saturation, resolve and gshare index.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        predict_taken;
  logic [5:0]  pred_idx;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [5:0]  ex_idx;
  logic [1:0]  pc_sel_ex;
  logic        branch_predict_ex;
  logic        branch_outcome;
  logic        predict_outcome;
  logic        pc_sel_default;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  int vecs = 0;
  int errs = 0;
  logic [5:0] g = '0;

  branch_predictor_bht dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_if             (pc_if),
    .predict_taken     (predict_taken),
    .pred_idx          (pred_idx),
    .ex_valid          (ex_valid),
    .ex_is_branch      (ex_is_branch),
    .ex_idx            (ex_idx),
    .pc_sel_ex         (pc_sel_ex),
    .branch_predict_ex (branch_predict_ex),
    .branch_outcome    (branch_outcome),
    .predict_outcome   (predict_outcome),
    .pc_sel_default    (pc_sel_default),
    .branch_cnt        (branch_cnt),
    .mispredict_cnt    (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc_for(input logic [5:0] idx);
`ifdef BHT_GSHARE_EN
    return {24'd0, idx ^ g, 2'b00};
`else
    return {24'd0, idx, 2'b00};
`endif
  endfunction

  task automatic tick();
    logic t;
    t = (pc_sel_ex == 2'd1) || (pc_sel_ex == 2'd2);
    @(posedge clk);
    if (ex_valid && ex_is_branch) g = {g[4:0], t};
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic [5:0] i,
                       input logic [1:0] s, input logic p);
    ex_valid = v;
    ex_is_branch = b;
    ex_idx = i;
    pc_sel_ex = s;
    branch_predict_ex = p;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    pc_if = 32'h40;
    drive(1'b0, 1'b0, 6'd0, 2'd0, 1'b0);
    #11;
    chk("rst_pred", predict_taken, 0);
    chk("rst_idx", pred_idx, 32'h10);
    chk("rst_bcnt", branch_cnt, 0);
    chk("rst_mcnt", mispredict_cnt, 0);
    chk("rst_pout", predict_outcome, 1);
    chk("rst_bout", branch_outcome, 0);
    rst_n = 1'b1;

    drive(1'b1, 1'b1, 6'h10, 2'd2, 1'b0);
    chk("t1_bout", branch_outcome, 1);
    chk("t1_pout", predict_outcome, 0);
    chk("t1_dflt", pc_sel_default, 0);
    tick();
    pc_if = pc_for(6'h10);
    #1;
    chk("t1_pred", predict_taken, 1);
    chk("t1_bht", dut.bht[16], 2);
    chk("t1_mcnt", mispredict_cnt, 1);
    drive(1'b1, 1'b1, 6'h10, 2'd2, 1'b1);
    chk("t2_pout", predict_outcome, 1);
    tick();
    tick();
    pc_if = pc_for(6'h10);
    #1;
    chk("t3_bht", dut.bht[16], 3);
    chk("t3_pred", predict_taken, 1);
    chk("t3_bcnt", branch_cnt, 3);
    chk("t3_mcnt", mispredict_cnt, 1);

    drive(1'b1, 1'b1, 6'h10, 2'd0, 1'b1);
    chk("df_dflt", pc_sel_default, 1);
    chk("df_pout", predict_outcome, 0);
    chk("df_bout", branch_outcome, 0);
    tick();
    chk("df_mcnt", mispredict_cnt, 2);
    chk("df_bcnt", branch_cnt, 4);
    chk("df_bht", dut.bht[16], 2);

    drive(1'b1, 1'b0, 6'h10, 2'd1, 1'b1);
    chk("jr_bout", branch_outcome, 1);
    chk("jr_pout", predict_outcome, 1);
    chk("jr_dflt", pc_sel_default, 0);
    tick();
    chk("jr_bcnt", branch_cnt, 4);
    chk("jr_bht", dut.bht[16], 2);

    drive(1'b0, 1'b1, 6'h10, 2'd2, 1'b0);
    chk("nv_bout", branch_outcome, 0);
    chk("nv_pout", predict_outcome, 1);
    tick();
    chk("nv_bcnt", branch_cnt, 4);
    chk("nv_mcnt", mispredict_cnt, 2);

    drive(1'b1, 1'b1, 6'd5, 2'd3, 1'b0);
    chk("ba_bout", branch_outcome, 0);
    chk("ba_pout", predict_outcome, 1);
    chk("ba_dflt", pc_sel_default, 0);
    drive(1'b1, 1'b1, 6'd5, 2'd2, 1'b0);
    pc_if = pc_for(6'd5);
    #1;
    chk("rw_idx", pred_idx, 5);
    chk("rw_old", predict_taken, 0);
    tick();
    pc_if = pc_for(6'd5);
    #1;
    chk("rw_new", predict_taken, 1);
    chk("rw_mcnt", mispredict_cnt, 3);

    drive(1'b1, 1'b1, 6'd5, 2'd3, 1'b1);
    tick();
    pc_if = pc_for(6'd5);
    #1;
    chk("dn_pred", predict_taken, 0);
    chk("dn_mcnt", mispredict_cnt, 4);
    drive(1'b1, 1'b1, 6'd5, 2'd0, 1'b0);
    tick();
    tick();
    chk("dn_bht0", dut.bht[5], 0);
    chk("dn_bcnt", branch_cnt, 8);
    chk("dn_mcnt2", mispredict_cnt, 4);

    drive(1'b0, 1'b0, 6'd5, 2'd0, 1'b0);
    force dut.mispredict_cnt = 16'hFFFF;
    #1;
    release dut.mispredict_cnt;
    #1;
    chk("sat_pre", mispredict_cnt, 32'hFFFF);
    drive(1'b1, 1'b1, 6'd5, 2'd2, 1'b0);
    tick();
    chk("sat_mcnt", mispredict_cnt, 32'hFFFF);
    chk("sat_bcnt", branch_cnt, 9);
    chk("sat_bht", dut.bht[5], 1);

    #3;
    rst_n = 1'b0;
    g = '0;
    #1;
    chk("mr_bcnt", branch_cnt, 0);
    chk("mr_mcnt", mispredict_cnt, 0);
    chk("mr_ghr", dut.ghr, 0);
    chk("mr_bht5", dut.bht[5], 1);
    chk("mr_bht16", dut.bht[16], 1);
    pc_if = 32'h40;
    #1;
    chk("mr_pred", predict_taken, 0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 1'b1, 6'h20, 2'd1, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b1, 6'h20, 2'd3, 1'b1);
    tick();
    drive(1'b0, 1'b0, 6'h20, 2'd0, 1'b0);
    chk("gh_ghr", dut.ghr, 32'h06);
    chk("gh_bht", dut.bht[32], 2);
    pc_if = 32'h40;
    #1;
`ifdef BHT_GSHARE_EN
    chk("gh_idx", pred_idx, 32'h16);
`else
    chk("gh_idx", pred_idx, 32'h10);
`endif
    pc_if = pc_for(6'h20);
    #1;
    chk("gh_pred", predict_taken, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
